// File: rtl/vehicle_sensor_cond_pkg.sv
// Shared light codes, channel state type and counter sizing for the loop-detector conditioner.
package vehicle_sensor_cond_pkg;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QUAL,
        ST_REQ,
        ST_SERVED,
        ST_FAULT
    } chan_state_e;

    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/vehicle_sensor_cond_if.sv
// Detector/light/request bundle between the intersection controller side and the conditioner.
interface vehicle_sensor_cond_if;
    logic       north_raw;
    logic       east_raw;
    logic [2:0] north_l;
    logic [2:0] east_l;
    logic       north_s;
    logic       east_s;
    logic       north_fault;
    logic       east_fault;

    modport master (
        output north_raw, east_raw, north_l, east_l,
        input  north_s, east_s, north_fault, east_fault
    );

    modport slave (
        input  north_raw, east_raw, north_l, east_l,
        output north_s, east_s, north_fault, east_fault
    );
endinterface

// File: rtl/vehicle_sensor_cond_sensor_channel.sv
// One direction: 2-flop synchronizer, debounce/stuck counter and request FSM.
// Stuck-sensor detection is compiled in only when SENSOR_STUCK_EN is defined.
module sensor_channel
    import vehicle_sensor_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    input  logic i_grn,
    output logic o_s,
    output logic o_fault
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, STUCK_CYCLES);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef SENSOR_STUCK_EN
    localparam logic [CNT_W-1:0] STK_LAST = CNT_W'(STUCK_CYCLES - 1);
`endif

    logic              r_meta;
    logic              r_sync;
    chan_state_e       r_state;
    chan_state_e       w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              r_s;
    logic              r_fault;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_grn) begin
                    w_state_next = ST_SERVED;
                    w_cnt_next   = '0;
                end else if (r_sync) begin
                    w_state_next = (DEBOUNCE_CYCLES == 1) ? ST_REQ : ST_QUAL;
                    w_cnt_next   = CNT_W'(1);
                end
            end
            ST_QUAL: begin
                if (i_grn) begin
                    w_state_next = ST_SERVED;
                    w_cnt_next   = '0;
                end else if (!r_sync) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_next = ST_REQ;
                end else begin
                    w_cnt_next = sat_inc(r_cnt);
                end
            end
            ST_REQ: begin
                // Only green releases a latched request; the raw line is ignored here.
                if (i_grn) begin
                    w_state_next = ST_SERVED;
                    w_cnt_next   = '0;
                end
            end
            ST_SERVED: begin
                if (!r_sync) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end
`ifdef SENSOR_STUCK_EN
                else if (r_cnt == STK_LAST) begin
                    w_state_next = ST_FAULT;
                end else begin
                    w_cnt_next = sat_inc(r_cnt);
                end
`endif
            end
            ST_FAULT: begin
                if (!r_sync) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_s     <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_meta  <= i_raw;
            r_sync  <= r_meta;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_s     <= (w_state_next == ST_REQ);
`ifdef SENSOR_STUCK_EN
            r_fault <= (w_state_next == ST_FAULT);
`else
            r_fault <= 1'b0;
`endif
        end
    end

    assign o_s     = r_s;
    assign o_fault = r_fault;

endmodule

// File: rtl/vehicle_sensor_cond.sv
// Loop-detector conditioner top: two independent sensor channels plus green decode.
// Optional stuck-sensor fault detection: define SENSOR_STUCK_EN.
module vehicle_sensor_cond
    import vehicle_sensor_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    vehicle_sensor_cond_if.slave  bus
);

    logic w_north_grn;
    logic w_east_grn;

    assign w_north_grn = (bus.north_l == LIGHT_GRN);
    assign w_east_grn  = (bus.east_l == LIGHT_GRN);

    sensor_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_north (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (bus.north_raw),
        .i_grn   (w_north_grn),
        .o_s     (bus.north_s),
        .o_fault (bus.north_fault)
    );

    sensor_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_east (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (bus.east_raw),
        .i_grn   (w_east_grn),
        .o_s     (bus.east_s),
        .o_fault (bus.east_fault)
    );

endmodule
